// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage MIPS pipeline.
// Computes the ALU result, resolves beq/bne/j into a registered redirect
// pulse and target, and kills the side effects of the SQUASH_DEPTH
// wrong-path instructions that follow a taken redirect.
// Optional feature macro: EX_OVERFLOW_TRAP_EN adds a sticky signed-overflow
// flag (ovf_sticky) and suppresses the register write of an overflowing add/sub.
module execute_stage #(
    parameter int unsigned SQUASH_DEPTH = 2,
    parameter int unsigned CNT_W        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALUctr,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] MD,
    input  logic [15:0] imm,
    input  logic [31:0] NPC,
    input  logic [31:0] JT,
    input  logic [4:0]  RD,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        branch,
    input  logic        jump,
    output logic        XM_MemtoReg,
    output logic        XM_RegWrite,
    output logic        XM_MemRead,
    output logic        XM_MemWrite,
    output logic [4:0]  XM_RD,
    output logic [31:0] ALUout,
    output logic [31:0] XM_MD,
    output logic        XM_BranchTaken,
`ifdef EX_OVERFLOW_TRAP_EN
    output logic        ovf_sticky,
`endif
    output logic [31:0] XM_BT
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_BEQ = 3'd5;
    localparam logic [2:0] OP_BNE = 3'd6;

    logic [CNT_W-1:0] sq_cnt_q, sq_cnt_d;
    logic             memtoreg_q, memtoreg_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic             memwrite_q, memwrite_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic [DW-1:0]    alu_q, alu_d;
    logic [DW-1:0]    md_q, md_d;
    logic             bt_taken_q, bt_taken_d;
    logic [DW-1:0]    bt_q, bt_d;
`ifdef EX_OVERFLOW_TRAP_EN
    logic             ovf_q, ovf_d;
    logic             ovf_c;
`endif

    logic [DW-1:0]    sum_c, diff_c, alu_c, br_tgt_c;
    logic             live_c, take_c;

    assign sum_c    = A + B;
    assign diff_c   = A - B;
    assign br_tgt_c = NPC + {{14{imm[15]}}, imm, 2'b00};
    assign live_c   = (sq_cnt_q == '0);
    assign take_c   = live_c & (jump
                              | (branch & (ALUctr == OP_BEQ) & (A == B))
                              | (branch & (ALUctr == OP_BNE) & (A != B)));

    // ALU result selection; beq/bne reuse the subtractor, jump yields 0.
    always_comb begin
        alu_c = '0;
        case (ALUctr)
            OP_ADD:         alu_c = sum_c;
            OP_SUB:         alu_c = diff_c;
            OP_AND:         alu_c = A & B;
            OP_OR:          alu_c = A | B;
            OP_SLT:         alu_c = ($signed(A) < $signed(B)) ? DW'(1) : '0;
            OP_BEQ, OP_BNE: alu_c = diff_c;
            default:        alu_c = '0;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    // Signed overflow on a live, non-memory add/sub.
    assign ovf_c = live_c & ~MemRead & ~MemWrite &
                   (((ALUctr == OP_ADD) & (A[DW-1] == B[DW-1]) & (sum_c[DW-1] != A[DW-1])) |
                    ((ALUctr == OP_SUB) & (A[DW-1] != B[DW-1]) & (diff_c[DW-1] != A[DW-1])));
`endif

    // Next-state: squash counter and the EX/MEM payload.
    always_comb begin
        sq_cnt_d   = sq_cnt_q;
        memtoreg_d = live_c & MemtoReg;
        regwrite_d = live_c & RegWrite;
        memread_d  = live_c & MemRead;
        memwrite_d = live_c & MemWrite;
        rd_d       = RD;
        alu_d      = alu_c;
        md_d       = MD;
        bt_taken_d = take_c;
        bt_d       = '0;
`ifdef EX_OVERFLOW_TRAP_EN
        ovf_d      = ovf_q;
`endif
        if (!live_c) begin
            sq_cnt_d = sq_cnt_q - CNT_W'(1);
        end else if (take_c) begin
            sq_cnt_d = CNT_W'(SQUASH_DEPTH);
        end
        if (take_c) begin
            bt_d = jump ? JT : br_tgt_c;
        end
`ifdef EX_OVERFLOW_TRAP_EN
        if (ovf_c) begin
            regwrite_d = 1'b0;
            ovf_d      = 1'b1;
        end
`endif
    end

    // Pipeline register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_cnt_q   <= '0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            rd_q       <= '0;
            alu_q      <= '0;
            md_q       <= '0;
            bt_taken_q <= 1'b0;
            bt_q       <= '0;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            sq_cnt_q   <= sq_cnt_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            md_q       <= md_d;
            bt_taken_q <= bt_taken_d;
            bt_q       <= bt_d;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign XM_MemtoReg    = memtoreg_q;
    assign XM_RegWrite    = regwrite_q;
    assign XM_MemRead     = memread_q;
    assign XM_MemWrite    = memwrite_q;
    assign XM_RD          = rd_q;
    assign ALUout         = alu_q;
    assign XM_MD          = md_q;
    assign XM_BranchTaken = bt_taken_q;
    assign XM_BT          = bt_q;
`ifdef EX_OVERFLOW_TRAP_EN
    assign ovf_sticky     = ovf_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: vector table applied through a scoreboard
// queue, plus hand-written reset-mid-squash and overflow-trap sequences.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  ALUctr = '0;
    logic [31:0] A = '0, B = '0, MD = '0, NPC = '0, JT = '0;
    logic [15:0] imm = '0;
    logic [4:0]  RD = '0;
    logic        MemtoReg = 1'b0, RegWrite = 1'b0, MemRead = 1'b0;
    logic        MemWrite = 1'b0, branch = 1'b0, jump = 1'b0;
    logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite;
    logic [4:0]  XM_RD;
    logic [31:0] ALUout, XM_MD, XM_BT;
    logic        XM_BranchTaken;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        ovf_sticky;
`endif

    execute_stage #(.SQUASH_DEPTH(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .ALUctr(ALUctr), .A(A), .B(B), .MD(MD),
        .imm(imm), .NPC(NPC), .JT(JT), .RD(RD),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .branch(branch), .jump(jump),
        .XM_MemtoReg(XM_MemtoReg), .XM_RegWrite(XM_RegWrite),
        .XM_MemRead(XM_MemRead), .XM_MemWrite(XM_MemWrite),
        .XM_RD(XM_RD), .ALUout(ALUout), .XM_MD(XM_MD),
        .XM_BranchTaken(XM_BranchTaken),
`ifdef EX_OVERFLOW_TRAP_EN
        .ovf_sticky(ovf_sticky),
`endif
        .XM_BT(XM_BT)
    );

    always #5 clk = ~clk;

    // ctl = {MemtoReg, RegWrite, MemRead, MemWrite, branch, jump}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_RW   = 6'b010000;
    localparam logic [5:0] C_LW   = 6'b111000;
    localparam logic [5:0] C_SW   = 6'b000100;
    localparam logic [5:0] C_BR   = 6'b000010;
    localparam logic [5:0] C_J    = 6'b000001;
    // xctl = {XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite}
    localparam logic [3:0] X_NONE = 4'b0000;
    localparam logic [3:0] X_RW   = 4'b0100;
    localparam logic [3:0] X_LW   = 4'b1110;
    localparam logic [3:0] X_SW   = 4'b0001;

    typedef struct {
        logic [2:0]  ctr;
        logic [31:0] a, b, md, npc, jt;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [5:0]  ctl;
    } in_t;

    typedef struct {
        logic [3:0]  xctl;
        logic [4:0]  xrd;
        logic [31:0] alu, xmd, bt;
        logic        tk;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;

    function automatic vec_t mk(input logic [2:0] ctr, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] md, input logic [15:0] im, input logic [31:0] npc,
                                input logic [31:0] jt, input logic [4:0] rd, input logic [5:0] ctl,
                                input logic [3:0] xctl, input logic [31:0] alu, input logic tk,
                                input logic [31:0] bt);
        vec_t v;
        v.in.ctr = ctr; v.in.a = a; v.in.b = b; v.in.md = md; v.in.imm = im;
        v.in.npc = npc; v.in.jt = jt; v.in.rd = rd; v.in.ctl = ctl;
        v.ex.xctl = xctl; v.ex.xrd = rd; v.ex.alu = alu; v.ex.xmd = md;
        v.ex.tk = tk; v.ex.bt = bt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got 0x%08h expected 0x%08h", name, cur, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        ALUctr = i.ctr; A = i.a; B = i.b; MD = i.md; imm = i.imm;
        NPC = i.npc; JT = i.jt; RD = i.rd;
        {MemtoReg, RegWrite, MemRead, MemWrite, branch, jump} = i.ctl;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".MemtoReg"}, 32'(XM_MemtoReg), 32'd0);
        chk({tag, ".RegWrite"}, 32'(XM_RegWrite), 32'd0);
        chk({tag, ".MemRead"},  32'(XM_MemRead),  32'd0);
        chk({tag, ".MemWrite"}, 32'(XM_MemWrite), 32'd0);
        chk({tag, ".RD"},       32'(XM_RD),       32'd0);
        chk({tag, ".ALUout"},   ALUout,           32'd0);
        chk({tag, ".MD"},       XM_MD,            32'd0);
        chk({tag, ".Taken"},    32'(XM_BranchTaken), 32'd0);
        chk({tag, ".BT"},       XM_BT,            32'd0);
    endtask

    // Pop the oldest expectation and compare against the registered outputs.
    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        chk("XM_MemtoReg", 32'(XM_MemtoReg), 32'(e.xctl[3]));
        chk("XM_RegWrite", 32'(XM_RegWrite), 32'(e.xctl[2]));
        chk("XM_MemRead",  32'(XM_MemRead),  32'(e.xctl[1]));
        chk("XM_MemWrite", 32'(XM_MemWrite), 32'(e.xctl[0]));
        chk("XM_RD",       32'(XM_RD),       32'(e.xrd));
        chk("ALUout",      ALUout,           e.alu);
        chk("XM_MD",       XM_MD,            e.xmd);
        chk("XM_BranchTaken", 32'(XM_BranchTaken), 32'(e.tk));
        chk("XM_BT",       XM_BT,            e.bt);
    endtask

    // Called at a negedge; drives one instruction and checks it after the next posedge.
    task automatic apply(input vec_t v);
        drive(v.in);
        sb_q.push_back(v.ex);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
        cur++;
    endtask

    vec_t vecs[21];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(3'd0, 32'd5, 32'd7, 0, 16'h0, 0, 0, 5'd3, C_RW, X_RW, 32'd12, 0, 0);
        vecs[1]  = mk(3'd4, 32'hFFFFFFFF, 32'd1, 0, 16'h0, 0, 0, 5'd4, C_RW, X_RW, 32'd1, 0, 0);
        vecs[2]  = mk(3'd1, 32'd3, 32'd5, 0, 16'h0, 0, 0, 5'd5, C_RW, X_RW, 32'hFFFFFFFE, 0, 0);
        vecs[3]  = mk(3'd2, 32'hF0F0, 32'hFF00, 0, 16'h0, 0, 0, 5'd6, C_RW, X_RW, 32'hF000, 0, 0);
        vecs[4]  = mk(3'd3, 32'hF0F0, 32'h0F00, 0, 16'h0, 0, 0, 5'd6, C_RW, X_RW, 32'hFFF0, 0, 0);
        vecs[5]  = mk(3'd4, 32'd1, 32'hFFFFFFFF, 0, 16'h0, 0, 0, 5'd4, C_RW, X_RW, 32'd0, 0, 0);
        vecs[6]  = mk(3'd0, 32'h1000, 32'd4, 0, 16'h0, 0, 0, 5'd7, C_LW, X_LW, 32'h1004, 0, 0);
        // taken beq, then two killed instructions, then a live one
        vecs[7]  = mk(3'd5, 32'd9, 32'd9, 0, 16'hFFFE, 32'h100, 0, 5'd0, C_BR, X_NONE, 32'd0, 1, 32'hF8);
        vecs[8]  = mk(3'd0, 32'd1, 32'd2, 0, 16'h0, 0, 0, 5'd8, C_RW, X_NONE, 32'd3, 0, 0);
        vecs[9]  = mk(3'd0, 32'h20, 32'd4, 32'hDEAD, 16'h0, 0, 0, 5'd0, C_SW, X_NONE, 32'h24, 0, 0);
        vecs[10] = mk(3'd0, 32'd10, 32'd20, 0, 16'h0, 0, 0, 5'd9, C_RW, X_RW, 32'd30, 0, 0);
        vecs[11] = mk(3'd6, 32'd4, 32'd4, 0, 16'h0010, 32'h300, 0, 5'd0, C_BR, X_NONE, 32'd0, 0, 0);
        // jump taken, a second jump inside the squash window is ignored
        vecs[12] = mk(3'd7, 32'd0, 32'd0, 0, 16'h0, 0, 32'h400, 5'd0, C_J, X_NONE, 32'd0, 1, 32'h400);
        vecs[13] = mk(3'd7, 32'd0, 32'd0, 0, 16'h0, 0, 32'h800, 5'd0, C_J, X_NONE, 32'd0, 0, 0);
        vecs[14] = mk(3'd0, 32'd1, 32'd1, 0, 16'h0, 0, 0, 5'd1, C_RW, X_NONE, 32'd2, 0, 0);
        // taken bne right after the window closes
        vecs[15] = mk(3'd6, 32'd3, 32'd4, 0, 16'h0004, 32'h200, 0, 5'd0, C_BR, X_NONE, 32'hFFFFFFFF, 1, 32'h210);
        vecs[16] = mk(3'd0, 32'd0, 32'd0, 0, 16'h0, 0, 0, 5'd2, C_RW, X_NONE, 32'd0, 0, 0);
        vecs[17] = mk(3'd0, 32'd0, 32'd0, 0, 16'h0, 0, 0, 5'd2, C_RW, X_NONE, 32'd0, 0, 0);
        vecs[18] = mk(3'd5, 32'd1, 32'd2, 0, 16'h0004, 32'h40, 0, 5'd0, C_BR, X_NONE, 32'hFFFFFFFF, 0, 0);
        vecs[19] = mk(3'd5, 32'd7, 32'd7, 0, 16'h0004, 32'h40, 0, 5'd0, C_NONE, X_NONE, 32'd0, 0, 0);
        vecs[20] = mk(3'd0, 32'd2, 32'd3, 32'hAB, 16'h0, 0, 0, 5'd10, C_SW, X_SW, 32'd5, 0, 0);

        // Reset state
        #1 rst = 1'b1;
        #2;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted one cycle after a taken beq clears everything asynchronously
        apply(mk(3'd5, 32'd9, 32'd9, 0, 16'hFFFE, 32'h100, 0, 5'd0, C_BR, X_NONE, 32'd0, 1, 32'hF8));
        drive(vecs[8].in);
        rst = 1'b1;
        #1;
        check_zero("mid_squash_reset");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(3'd0, 32'h100, 32'd8, 0, 16'h0, 0, 0, 5'd11, C_LW, X_LW, 32'h108, 0, 0));
        apply(mk(3'd0, 32'd4, 32'd4, 0, 16'h0, 0, 0, 5'd12, C_RW, X_RW, 32'd8, 0, 0));

`ifdef EX_OVERFLOW_TRAP_EN
        chk("ovf_sticky_clear", 32'(ovf_sticky), 32'd0);
        apply(mk(3'd0, 32'h7FFFFFFF, 32'd1, 0, 16'h0, 0, 0, 5'd1, C_RW, X_NONE, 32'h80000000, 0, 0));
        chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
        apply(mk(3'd0, 32'h7FFFFFFF, 32'd1, 0, 16'h0, 0, 0, 5'd2, C_LW, X_LW, 32'h80000000, 0, 0));
        apply(mk(3'd1, 32'h80000000, 32'd1, 0, 16'h0, 0, 0, 5'd3, C_RW, X_NONE, 32'h7FFFFFFF, 0, 0));
        apply(mk(3'd0, 32'd1, 32'd1, 0, 16'h0, 0, 0, 5'd4, C_RW, X_RW, 32'd2, 0, 0));
        chk("ovf_sticky_hold", 32'(ovf_sticky), 32'd1);
        rst = 1'b1;
        #1;
        chk("ovf_sticky_rst", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
